window_mc: RTL and testbench

//  Multi-channel streaming window (apodisation) stage placed ahead of the FFT.
//  - Multiplies each sample by a per-index coefficient from a runtime-loadable table.
//  - Rounds the result convergently and marks frame boundaries.
//  - Uses valid/ready handshakes on both sides.
//  - All CHANNELS lanes share one index counter and one coefficient table.

---
 rtl/window_mc_if.sv | 34 +++
 rtl/window_mc.sv | 195 +++++++++++++++++++
 tb/tb_window_mc.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_mc_if.sv
// ---------------------------------------------------------------------------
// window_mc_if
// Streaming bundle for the window_mc apodisation stage.
//   s_valid / s_ready / s_data : sample input handshake, lane 0 in the LSBs
//   resync                     : next accepted sample restarts at frame index 0
//   m_valid / m_ready / m_data : windowed sample output handshake
//   m_last                     : output sample carries frame index N-1
// Modports:
//   master : the side that feeds samples in and consumes the windowed output
//   slave  : the window_mc block itself
// ---------------------------------------------------------------------------
interface window_mc_if #(
    parameter int DATA_WIDTH = 14,
    parameter int CHANNELS   = 2
);
    logic                           s_valid;
    logic                           s_ready;
    logic [CHANNELS*DATA_WIDTH-1:0] s_data;
    logic                           resync;
    logic                           m_valid;
    logic                           m_ready;
    logic [CHANNELS*DATA_WIDTH-1:0] m_data;
    logic                           m_last;

    modport master (
        output s_valid, s_data, resync, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, resync, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/window_mc.sv
// ---------------------------------------------------------------------------
// window_mc
// Multi-channel streaming window stage ahead of the FFT. Every lane's sample
// is multiplied by an unsigned coefficient (value c/2^COEFF_WIDTH) picked by a
// shared frame index, rounded half-to-even and passed on with a frame marker.
// Three pipeline stages (register+table read, multiply, round) advance
// together whenever the output register is free or being drained.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   st (slave modport)   s_valid/s_ready/s_data/resync in,
//                        m_valid/m_ready/m_data/m_last out
//   coef_we/addr/data    coefficient table write port
//   cfg_err              sticky flag: a table write was rejected
//
// Build option: define WINDOW_SYMMETRIC_EN to store only N/2 coefficients and
// mirror the second half of the frame onto them.
// ---------------------------------------------------------------------------
module window_mc #(
    parameter int    N           = 1024,
    parameter int    DATA_WIDTH  = 14,
    parameter int    COEFF_WIDTH = 16,
    parameter int    CHANNELS    = 2,
    parameter string COEFF_FILE  = ""
) (
    input  logic                   clk,
    input  logic                   rst_n,
    window_mc_if.slave             st,
    input  logic                   coef_we,
    input  logic [$clog2(N)-1:0]   coef_addr,
    input  logic [COEFF_WIDTH-1:0] coef_data,
    output logic                   cfg_err
);
    localparam int AW = $clog2(N);
    localparam int PW = DATA_WIDTH + COEFF_WIDTH + 1;
    localparam int QW = PW - COEFF_WIDTH;
    localparam int SW = CHANNELS * DATA_WIDTH;
`ifdef WINDOW_SYMMETRIC_EN
    localparam int TAW = AW - 1;
`else
    localparam int TAW = AW;
`endif
    localparam int            DEPTH    = 1 << TAW;
    localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [COEFF_WIDTH-1:0] coef_mem [DEPTH];

    state_t                 state_r;
    logic [AW-1:0]          ctr_r;
    logic                   cfg_err_r;
    logic                   v1_r, v2_r, m_valid_r;
    logic                   last1_r, last2_r, m_last_r;
    logic [SW-1:0]          d1_r;
    logic [COEFF_WIDTH-1:0] c1_r;
    logic signed [PW-1:0]   prod_r [CHANNELS];
    logic [SW-1:0]          m_data_r;

    logic                   adv_s;
    logic                   accept_s;
    logic [AW-1:0]          idx_eff_s;
    logic                   idx_last_s;
    logic [TAW-1:0]         rd_addr_s;
    logic                   addr_ok_s;
    logic                   pipe_empty_s;
    logic                   write_ok_s;

    // Divide by 2^COEFF_WIDTH with round-half-to-even; |result| <= |d| so the
    // low DATA_WIDTH bits always hold the full value.
    function automatic logic [DATA_WIDTH-1:0] round_half_even(input logic signed [PW-1:0] p);
        logic [QW-1:0]          q;
        logic [COEFF_WIDTH-1:0] frac;
        logic [COEFF_WIDTH-1:0] half;
        logic                   up;
        q    = p[PW-1:COEFF_WIDTH];
        frac = p[COEFF_WIDTH-1:0];
        half = {1'b1, {(COEFF_WIDTH-1){1'b0}}};
        if (frac > half) begin
            up = 1'b1;
        end else if (frac == half) begin
            up = q[0];
        end else begin
            up = 1'b0;
        end
        q = q + {{(QW-1){1'b0}}, up};
        return q[DATA_WIDTH-1:0];
    endfunction

    // Handshake, frame index selection and table-write qualification.
    always_comb begin
        adv_s    = !m_valid_r || st.m_ready;
        accept_s = st.s_valid && adv_s;
        if (st.resync) begin
            idx_eff_s = {AW{1'b0}};
        end else begin
            idx_eff_s = ctr_r;
        end
        idx_last_s   = (idx_eff_s == IDX_LAST);
        pipe_empty_s = !v1_r && !v2_r && !m_valid_r;
`ifdef WINDOW_SYMMETRIC_EN
        // For i >= N/2 the mirrored index N-1-i is simply ~i in AW bits.
        if (idx_eff_s[AW-1]) begin
            rd_addr_s = ~idx_eff_s[TAW-1:0];
        end else begin
            rd_addr_s = idx_eff_s[TAW-1:0];
        end
        addr_ok_s = !coef_addr[AW-1];
`else
        rd_addr_s = idx_eff_s;
        addr_ok_s = 1'b1;
`endif
        // A write racing the frame-start acceptance counts as a write in RUN.
        write_ok_s = coef_we && addr_ok_s && (state_r == ST_IDLE) && !accept_s && pipe_empty_s;
    end

    // Coefficient table write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (write_ok_s) begin
            coef_mem[coef_addr[TAW-1:0]] <= coef_data;
        end
    end

    // Frame FSM with the shared index counter and the sticky config error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ctr_r     <= {AW{1'b0}};
            cfg_err_r <= 1'b0;
        end else begin
            if (accept_s) begin
                ctr_r <= idx_last_s ? {AW{1'b0}} : idx_eff_s + {{(AW-1){1'b0}}, 1'b1};
            end else if (st.resync) begin
                ctr_r <= {AW{1'b0}};
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (idx_eff_s == {AW{1'b0}})) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if ((accept_s && idx_last_s) || (st.resync && !accept_s)) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
            if (coef_we && !write_ok_s) begin
                cfg_err_r <= 1'b1;
            end
        end
    end

    // Three-stage datapath: capture+read, multiply, round; stalls as a unit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_r      <= 1'b0;
            v2_r      <= 1'b0;
            m_valid_r <= 1'b0;
            last1_r   <= 1'b0;
            last2_r   <= 1'b0;
            m_last_r  <= 1'b0;
            d1_r      <= {SW{1'b0}};
            c1_r      <= {COEFF_WIDTH{1'b0}};
            m_data_r  <= {SW{1'b0}};
            for (int k = 0; k < CHANNELS; k++) begin
                prod_r[k] <= {PW{1'b0}};
            end
        end else if (adv_s) begin
            v1_r    <= accept_s;
            last1_r <= idx_last_s;
            d1_r    <= st.s_data;
            c1_r    <= coef_mem[rd_addr_s];
            v2_r    <= v1_r;
            last2_r <= last1_r;
            for (int k = 0; k < CHANNELS; k++) begin
                prod_r[k] <= PW'($signed(d1_r[k*DATA_WIDTH +: DATA_WIDTH])) *
                             PW'($signed({1'b0, c1_r}));
                m_data_r[k*DATA_WIDTH +: DATA_WIDTH] <= round_half_even(prod_r[k]);
            end
            m_valid_r <= v2_r;
            m_last_r  <= last2_r;
        end
    end

    assign st.s_ready = adv_s;
    assign st.m_valid = m_valid_r;
    assign st.m_data  = m_data_r;
    assign st.m_last  = m_last_r;
    assign cfg_err    = cfg_err_r;
endmodule

// File: tb/tb_window_mc.sv
// ---------------------------------------------------------------------------
// tb_window_mc
// Directed bench for window_mc with N=16, two 14-bit lanes, 16-bit coeffs.
// Outputs are collected on the falling edge whenever a transfer happens and
// compared against hand-computed values or a half-to-even rounding model.
// ---------------------------------------------------------------------------
module tb_window_mc;
    localparam int N  = 16;
    localparam int DW = 14;
    localparam int CW = 16;
    localparam int CH = 2;
`ifdef WINDOW_SYMMETRIC_EN
    localparam int NTAB = N / 2;
`else
    localparam int NTAB = N;
`endif

    typedef struct {
        int a;
        int b;
        int ea;
        int eb;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [15:0] coef_data;
    logic        cfg_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [27:0] oq[$];
    logic        lq[$];
    vec_t        vt[5];
    logic [27:0] sd;

    window_mc_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus ();

    window_mc #(
        .N(N), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .CHANNELS(CH), .COEFF_FILE("")
    ) dut (
        .clk(clk), .rst_n(rst_n), .st(bus),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && bus.m_valid && bus.m_ready) begin
            oq.push_back(bus.m_data);
            lq.push_back(bus.m_last);
        end
    end

    function automatic int rhe(input longint p);
        longint q;
        longint r;
        q = p >>> 16;
        r = p - (q <<< 16);
        if (r > 64'sd32768) q = q + 1;
        else if (r == 64'sd32768 && q[0]) q = q + 1;
        return int'(q);
    endfunction

    function automatic int taddr(input int k);
`ifdef WINDOW_SYMMETRIC_EN
        if (k >= N / 2) return N - 1 - k;
`endif
        return k;
    endfunction

    function automatic int ctab(input int k);
        return taddr(k) * 4096;
    endfunction

    function automatic logic [27:0] pk(input int a, input int b);
        logic [13:0] la;
        logic [13:0] lb;
        la = a[13:0];
        lb = b[13:0];
        return {lb, la};
    endfunction

    function automatic logic [27:0] ex(input int a, input int b, input int c);
        return pk(rhe(longint'(a) * c), rhe(longint'(b) * c));
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input int a, input int b, input logic rs);
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = pk(a, b);
        bus.resync  = rs;
        @(negedge clk);
        while (!bus.s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.resync  = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = a[3:0];
        coef_data = d[15:0];
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n, input string nm);
        int k;
        k = 0;
        while (oq.size() < n && k < 200) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(nm, 32'(oq.size()), 32'(n));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Coefficient 0.5 everywhere: ties must go to even.
        vt[0] = '{3,     1,     2,    0};
        vt[1] = '{5,     7,     2,    4};
        vt[2] = '{-3,    -1,    -2,   0};
        vt[3] = '{-5,    -7,    -2,   -4};
        vt[4] = '{8191,  -8191, 4096, -4096};

        bus.s_valid = 1'b0;
        bus.s_data  = 28'h0;
        bus.resync  = 1'b0;
        bus.m_ready = 1'b1;
        coef_we     = 1'b0;
        coef_addr   = 4'h0;
        coef_data   = 16'h0;
        do_reset();

        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_last",  32'(bus.m_last),  32'd0);
        check("rst_m_data",  32'(bus.m_data),  32'd0);
        check("rst_cfg_err", 32'(cfg_err),     32'd0);
        check("rst_s_ready", 32'(bus.s_ready), 32'd1);

        // Test 1: table vectors at coefficient 0x8000.
        for (int e = 0; e < NTAB; e++) wr(e, 32'h8000);
        oq.delete(); lq.delete();
        for (int i = 0; i < 5; i++) send(vt[i].a, vt[i].b, 1'b0);
        drain(5, "t1_count");
        for (int i = 0; i < 5; i++) begin
            if (i < oq.size()) begin
                check($sformatf("t1_data[%0d]", i), 32'(oq[i]), 32'(pk(vt[i].ea, vt[i].eb)));
                check($sformatf("t1_last[%0d]", i), 32'(lq[i]), 32'd0);
            end
        end

        // resync with no acceptance returns to IDLE, so the table is writable again.
        bus.resync = 1'b1;
        @(posedge clk);
        #1;
        bus.resync = 1'b0;
        for (int e = 0; e < NTAB; e++) wr(e, e * 4096);
        check("t2_wr_after_resync", 32'(cfg_err), 32'd0);

        // Test 2: 40 samples over a ramp table; m_last only at 15 and 31.
        oq.delete(); lq.delete();
        for (int j = 0; j < 40; j++) send(37 * j - 700, 8191 - 400 * j, 1'b0);
        drain(40, "t2_count");
        for (int j = 0; j < 40; j++) begin
            if (j < oq.size()) begin
                check($sformatf("t2_data[%0d]", j), 32'(oq[j]),
                      32'(ex(37 * j - 700, 8191 - 400 * j, ctab(j % 16))));
                check($sformatf("t2_last[%0d]", j), 32'(lq[j]), 32'((j % 16) == 15));
            end
        end

        // Test 3: downstream stall mid-frame (indices 8..11).
        oq.delete(); lq.delete();
        send(100, -100, 1'b0);
        send(200, -200, 1'b0);
        send(300, -300, 1'b0);
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = pk(400, -400);
        sd = bus.m_data;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("t3_valid[%0d]", c), 32'(bus.m_valid), 32'd1);
            check($sformatf("t3_data[%0d]", c),  32'(bus.m_data),  32'(sd));
            check($sformatf("t3_sready[%0d]", c), 32'(bus.s_ready), 32'd0);
        end
        bus.m_ready = 1'b1;
        #1;
        check("t3_sready_release", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        drain(4, "t3_count");
        for (int i = 0; i < 4; i++) begin
            if (i < oq.size())
                check($sformatf("t3_out[%0d]", i), 32'(oq[i]),
                      32'(ex(100 * (i + 1), -100 * (i + 1), ctab(8 + i))));
        end

        // Test 4: write during RUN is dropped and flags cfg_err.
        wr(taddr(13), 32'hFFFF);
        check("t4_cfg_err_run", 32'(cfg_err), 32'd1);
        oq.delete(); lq.delete();
        send(1000, -1000, 1'b0);
        send(2000, -3000, 1'b0);
        drain(2, "t4_count");
        if (oq.size() == 2) begin
            check("t4_idx12", 32'(oq[0]), 32'(ex(1000, -1000, ctab(12))));
            check("t4_idx13", 32'(oq[1]), 32'(ex(2000, -3000, ctab(13))));
        end
        do_reset();
        check("t4_cfg_err_rst", 32'(cfg_err), 32'd0);
        wr(0, 32'hC000);
        check("t4_cfg_err_idle", 32'(cfg_err), 32'd0);
        oq.delete(); lq.delete();
        send(5, -6, 1'b0);
        drain(1, "t4_new_count");
        if (oq.size() == 1) check("t4_new_coef", 32'(oq[0]), 32'(pk(4, -4)));

        // Test 5: reset with index 7 just accepted and three tokens in flight.
        for (int j = 1; j <= 7; j++) send(10 * j, -10 * j, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t5_m_valid", 32'(bus.m_valid), 32'd0);
        check("t5_m_last",  32'(bus.m_last),  32'd0);
        rst_n = 1'b1;
        oq.delete(); lq.delete();
        send(100, -100, 1'b0);
        drain(1, "t5_count");
        if (oq.size() == 1) check("t5_idx0", 32'(oq[0]), 32'(pk(75, -75)));

        // Test 6: symmetric addressing (or direct addressing in the default build).
        do_reset();
        wr(3, 32'h4000);
`ifdef WINDOW_SYMMETRIC_EN
        check("t6_cfg_ok", 32'(cfg_err), 32'd0);
        wr(8, 32'h1234);
        check("t6_addr8_rej", 32'(cfg_err), 32'd1);
        sd = pk(100, -100);
`else
        wr(12, 32'h2000);
        check("t6_cfg_ok", 32'(cfg_err), 32'd0);
        sd = pk(50, -50);
`endif
        oq.delete(); lq.delete();
        for (int j = 0; j < 16; j++) send(400, -400, 1'b0);
        drain(16, "t6_count");
        if (oq.size() == 16) begin
            check("t6_idx3",  32'(oq[3]),  32'(pk(100, -100)));
            check("t6_idx12", 32'(oq[12]), 32'(sd));
            check("t6_last",  32'(lq[15]), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
